// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared widths, control-bundle bit indices, forwarding encodings and the ID/EX payload type.
package id_ex_pipe_reg_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned CTRL_W = 8;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 32;

    // Control bundle: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op[1:0]}
    localparam int unsigned CTRL_REG_WRITE = 7;
    localparam int unsigned CTRL_MEM_READ  = 6;
    localparam int unsigned CTRL_MEM_WRITE = 5;
    localparam int unsigned CTRL_MEM_TO_REG = 4;
    localparam int unsigned CTRL_ALU_SRC   = 3;
    localparam int unsigned CTRL_BRANCH    = 2;
    localparam int unsigned CTRL_ALU_OP_HI = 1;
    localparam int unsigned CTRL_ALU_OP_LO = 0;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [CTRL_W-1:0] ctrl;
    } id_ex_payload_t;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID-side inputs, WB bypass source and EX-side outputs of the ID/EX pipeline register.
interface id_ex_pipe_reg_if;
    import id_ex_pipe_reg_pkg::*;

    logic                id_valid;
    logic [XLEN-1:0]     id_pc;
    logic [XLEN-1:0]     id_rs1_data;
    logic [XLEN-1:0]     id_rs2_data;
    logic [XLEN-1:0]     id_imm;
    logic [REG_AW-1:0]   id_rs1;
    logic [REG_AW-1:0]   id_rs2;
    logic [REG_AW-1:0]   id_rd;
    logic [CTRL_W-1:0]   id_ctrl;

    logic                wb_reg_write;
    logic [REG_AW-1:0]   wb_rd;
    logic [XLEN-1:0]     wb_data;

    logic                ex_valid;
    logic [XLEN-1:0]     ex_pc;
    logic [XLEN-1:0]     ex_rs1_data;
    logic [XLEN-1:0]     ex_rs2_data;
    logic [XLEN-1:0]     ex_imm;
    logic [REG_AW-1:0]   ex_rs1;
    logic [REG_AW-1:0]   ex_rs2;
    logic [REG_AW-1:0]   ex_rd;
    logic [CTRL_W-1:0]   ex_ctrl;
    logic                load_use_hazard;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_ctrl,
        output wb_reg_write, wb_rd, wb_data,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
        input  load_use_hazard
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_ctrl,
        input  wb_reg_write, wb_rd, wb_data,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
        output load_use_hazard
    );

endinterface

// File: rtl/id_ex_pipe_reg_wb_bypass_sel.sv
// Per-operand write-back bypass: replaces the operand with wb_data when WB writes the same non-x0 register.
module wb_bypass_sel
    import id_ex_pipe_reg_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   base_data,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   data_c
);

    fwd_sel_e sel_c;

    always_comb begin
        sel_c = FWD_REG;
        if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
            sel_c = FWD_WB;
        end
    end

    always_comb begin
        data_c = base_data;
        if (sel_c == FWD_WB) begin
            data_c = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall hold, flush-to-bubble, WB bypass and load-use hazard detect.
// Optional bubble counter output enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_pipe_reg
    import id_ex_pipe_reg_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
`ifdef ID_EX_BUBBLE_CNT_EN
    output logic [CNT_W-1:0] bubble_count,
`endif
    id_ex_pipe_reg_if.slave  bus
);

    id_ex_payload_t    ex_q;
    logic [REG_AW-1:0] rs1_src_c;
    logic [REG_AW-1:0] rs2_src_c;
    logic [XLEN-1:0]   rs1_base_c;
    logic [XLEN-1:0]   rs2_base_c;
    logic [XLEN-1:0]   rs1_byp_c;
    logic [XLEN-1:0]   rs2_byp_c;

    // On stall the bypass compares against the held addresses, otherwise against the incoming ones.
    assign rs1_src_c  = stall ? ex_q.rs1      : bus.id_rs1;
    assign rs2_src_c  = stall ? ex_q.rs2      : bus.id_rs2;
    assign rs1_base_c = stall ? ex_q.rs1_data : bus.id_rs1_data;
    assign rs2_base_c = stall ? ex_q.rs2_data : bus.id_rs2_data;

    wb_bypass_sel u_byp_rs1 (
        .rs           (rs1_src_c),
        .base_data    (rs1_base_c),
        .wb_reg_write (bus.wb_reg_write),
        .wb_rd        (bus.wb_rd),
        .wb_data      (bus.wb_data),
        .data_c       (rs1_byp_c)
    );

    wb_bypass_sel u_byp_rs2 (
        .rs           (rs2_src_c),
        .base_data    (rs2_base_c),
        .wb_reg_write (bus.wb_reg_write),
        .wb_rd        (bus.wb_rd),
        .wb_data      (bus.wb_data),
        .data_c       (rs2_byp_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else if (flush) begin
            ex_q.valid <= 1'b0;
            ex_q.ctrl  <= '0;
            ex_q.rd    <= '0;
        end else if (stall) begin
            ex_q.rs1_data <= rs1_byp_c;
            ex_q.rs2_data <= rs2_byp_c;
        end else begin
            ex_q <= '{valid:    bus.id_valid,
                      pc:       bus.id_pc,
                      rs1_data: rs1_byp_c,
                      rs2_data: rs2_byp_c,
                      imm:      bus.id_imm,
                      rs1:      bus.id_rs1,
                      rs2:      bus.id_rs2,
                      rd:       bus.id_rd,
                      ctrl:     bus.id_ctrl};
        end
    end

    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_pc       = ex_q.pc;
    assign bus.ex_rs1_data = ex_q.rs1_data;
    assign bus.ex_rs2_data = ex_q.rs2_data;
    assign bus.ex_imm      = ex_q.imm;
    assign bus.ex_rs1      = ex_q.rs1;
    assign bus.ex_rs2      = ex_q.rs2;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_ctrl     = ex_q.ctrl;

    // A load in EX whose destination is read by the instruction in ID.
    assign bus.load_use_hazard = ex_q.valid & ex_q.ctrl[CTRL_MEM_READ] & (ex_q.rd != '0) &
                                 bus.id_valid &
                                 ((ex_q.rd == bus.id_rs1) | (ex_q.rd == bus.id_rs2));

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_q;

    // Counts edges that write an invalid slot; saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_q <= '0;
        end else if (flush || (!stall && !bus.id_valid)) begin
            if (bubble_q != '1) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
        end
    end

    assign bubble_count = bubble_q;
`endif

endmodule
